// File: rtl/ixc_mem_resp_pkg.sv
// ixc_mem_resp_pkg
// Shared types and constants for the memory-call responder.
//   state_e     : responder FSM states (IDLE, ACCESS, RESP)
//   req_entry_t : one queued request {we, addr, data, tag} at the default widths
//   STATE_W     : width of the state encoding
//   entry_width : packed width of a request entry for arbitrary DW/AW/TW
package ixc_mem_resp_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 4;
  localparam int DEF_TW = 1;

  // Field order here is the same order the FIFO vector is packed in:
  // we in the MSB, tag in the LSBs.
  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
    logic [DEF_TW-1:0] tag;
  } req_entry_t;

  function automatic int entry_width(input int dw, input int aw, input int tw);
    return 1 + aw + dw + tw;
  endfunction

endpackage

// File: rtl/ixc_mem_resp_fifo.sv
// ixc_mem_resp_fifo
// QD-entry request queue holding packed {we, addr, data, tag} vectors.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (pointers only)
//   push_i, wr_data_i : write one entry (ignored while full)
//   pop_i           : retire the head entry (ignored while empty)
//   rd_data_o       : current head entry (combinational view)
//   full_o, empty_o : occupancy flags from registered pointers
module ixc_mem_resp_fifo
  import ixc_mem_resp_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4,
  parameter int TW = 1,
  parameter int QD = 4,
  localparam int EW = entry_width(DW, AW, TW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [EW-1:0] wr_data_i,
  input  logic          pop_i,
  output logic [EW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);

  // One extra pointer bit distinguishes full from empty; wraps mod 2*QD.
  localparam int PW = $clog2(QD) + 1;

  logic [EW-1:0] slot_q [QD];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;

  assign full_o  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                   (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign rd_data_o = slot_q[rptr_q[PW-2:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + PW'(1);
      if (pop_i && !empty_o) rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage is not reset; stale slots are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) slot_q[wptr_q[PW-2:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ixc_mem_resp.sv
// ixc_mem_resp
// Responder end of the memory-call channel. Queues s2h read/write calls,
// services them in order against a local word-addressed memory and returns
// an h2s response that is held until acknowledged.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   s2h_notify/we/addr/data/tag     : incoming call (one per notify cycle)
//   s2h_busy                        : queue full, a call this cycle is dropped
//   h2s_notify/wr/data/tag, h2s_ack : response handshake
//   ovf                             : sticky, a call arrived while busy
//   req_cnt                         : accepted-call count (saturating)
// Build option: define IXC_MEM_RESP_STATS_EN to enable req_cnt; otherwise
// it is tied to zero and the counter is not built.
module ixc_mem_resp
  import ixc_mem_resp_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4,
  parameter int TW = 1,
  parameter int QD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s2h_notify,
  input  logic          s2h_we,
  input  logic [AW-1:0] s2h_addr,
  input  logic [DW-1:0] s2h_data,
  input  logic [TW-1:0] s2h_tag,
  output logic          s2h_busy,
  output logic          h2s_notify,
  output logic          h2s_wr,
  output logic [DW-1:0] h2s_data,
  output logic [TW-1:0] h2s_tag,
  input  logic          h2s_ack,
  output logic          ovf,
  output logic [15:0]   req_cnt
);

  localparam int EW = entry_width(DW, AW, TW);

  state_e        state_q, state_d;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head_data;
  logic [EW-1:0] hold_q;

  logic          h2s_wr_q;
  logic [DW-1:0] h2s_data_q;
  logic [TW-1:0] h2s_tag_q;
  logic          ovf_q;

  logic [DW-1:0] mem_q [2**AW];

  // Unpacked view of the request currently being serviced.
  logic          hold_we;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;
  logic [TW-1:0] hold_tag;

  assign hold_we   = hold_q[EW-1];
  assign hold_addr = hold_q[TW+DW +: AW];
  assign hold_data = hold_q[TW +: DW];
  assign hold_tag  = hold_q[0 +: TW];

  assign push      = s2h_notify && !fifo_full;
  assign push_data = {s2h_we, s2h_addr, s2h_data, s2h_tag};

  ixc_mem_resp_fifo #(
    .DW(DW),
    .AW(AW),
    .TW(TW),
    .QD(QD)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (push_data),
    .pop_i     (pop),
    .rd_data_o (head_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Pop happens on the transition into ACCESS, so a waiting request is
  // picked up straight from RESP without a detour through IDLE.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (h2s_ack) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ACCESS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      h2s_wr_q   <= 1'b0;
      h2s_data_q <= '0;
      h2s_tag_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) hold_q <= head_data;
      if (s2h_notify && fifo_full) ovf_q <= 1'b1;
      // Response fields only change in ACCESS, which keeps them stable
      // for the whole time RESP waits on an ack.
      if (state_q == ACCESS) begin
        h2s_wr_q   <= hold_we;
        h2s_tag_q  <= hold_tag;
        h2s_data_q <= hold_we ? '0 : mem_q[hold_addr];
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && hold_we) mem_q[hold_addr] <= hold_data;
  end

  assign s2h_busy   = fifo_full;
  assign h2s_notify = (state_q == RESP);
  assign h2s_wr     = h2s_wr_q;
  assign h2s_data   = h2s_data_q;
  assign h2s_tag    = h2s_tag_q;
  assign ovf        = ovf_q;

`ifdef IXC_MEM_RESP_STATS_EN
  logic [15:0] req_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt_q <= '0;
    end else if (push && req_cnt_q != 16'hFFFF) begin
      req_cnt_q <= req_cnt_q + 16'd1;
    end
  end

  assign req_cnt = req_cnt_q;
`else
  assign req_cnt = '0;
`endif

endmodule

// File: tb/tb_ixc_mem_resp.sv
// tb_ixc_mem_resp
// Self-checking bench for ixc_mem_resp at default parameters. A reference
// model keeps a word array plus an in-order queue of expected responses;
// a read's expected data is fixed when it is accepted, because service is
// strictly in order. Honours IXC_MEM_RESP_STATS_EN for req_cnt.
module tb_ixc_mem_resp;
  import ixc_mem_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s2h_notify, s2h_we, s2h_busy;
  logic [3:0]  s2h_addr;
  logic [31:0] s2h_data;
  logic [0:0]  s2h_tag;
  logic        h2s_notify, h2s_wr, h2s_ack, ovf;
  logic [31:0] h2s_data;
  logic [0:0]  h2s_tag;
  logic [15:0] req_cnt;

  always #5 clk = ~clk;

  ixc_mem_resp dut (
    .clk(clk), .rst(rst),
    .s2h_notify(s2h_notify), .s2h_we(s2h_we), .s2h_addr(s2h_addr),
    .s2h_data(s2h_data), .s2h_tag(s2h_tag), .s2h_busy(s2h_busy),
    .h2s_notify(h2s_notify), .h2s_wr(h2s_wr), .h2s_data(h2s_data),
    .h2s_tag(h2s_tag), .h2s_ack(h2s_ack), .ovf(ovf), .req_cnt(req_cnt)
  );

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic [0:0]  tag;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] mdl_mem [16];
  bit          mdl_valid [16];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_cnt = 0;

`ifdef IXC_MEM_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  function automatic logic [15:0] exp_req_cnt();
    return STATS ? 16'(exp_cnt) : 16'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one request for the coming edge; update the model if the bench
  // expects it to be accepted.
  task automatic send(input req_entry_t r, input bit accept);
    resp_t e;
    s2h_notify = 1'b1;
    s2h_we     = r.we;
    s2h_addr   = r.addr;
    s2h_data   = r.data;
    s2h_tag    = r.tag;
    if (accept) begin
      e.wr   = r.we;
      e.data = r.we ? 32'd0 : mdl_mem[r.addr];
      e.tag  = r.tag;
      exp_q.push_back(e);
      if (r.we) begin
        mdl_mem[r.addr]   = r.data;
        mdl_valid[r.addr] = 1'b1;
      end
      if (exp_cnt < 65535) exp_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    n_cmp++; if (s2h_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", s2h_busy); end
    n_cmp++; if (h2s_notify !== 1'b0) begin n_bad++; $display("FAIL reset_notify: got %b want 0", h2s_notify); end
    n_cmp++; if (h2s_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b want 0", h2s_wr); end
    n_cmp++; if (h2s_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", h2s_data); end
    n_cmp++; if (h2s_tag !== 1'b0) begin n_bad++; $display("FAIL reset_tag: got %b want 0", h2s_tag); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (req_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_req_cnt: got %0d want 0", req_cnt); end
    $display("reset: outputs checked");
  endtask

  task automatic test_write_read();
    resp_t e;
    h2s_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) send('{we: 1'b1, addr: 4'd3, data: 32'hDEADBEEF, tag: 1'b1}, 1'b1);
      else        send('{we: 1'b0, addr: 4'd3, data: 32'h0, tag: 1'b0}, 1'b1);
      tick();
      s2h_notify = 1'b0;
      n_cmp++; if (h2s_notify !== 1'b0) begin n_bad++; $display("FAIL lat_c1[%0d]: notify got %b want 0", k, h2s_notify); end
      tick();
      n_cmp++; if (h2s_notify !== 1'b0) begin n_bad++; $display("FAIL lat_c2[%0d]: notify got %b want 0", k, h2s_notify); end
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (h2s_notify !== 1'b1) begin n_bad++; $display("FAIL lat_c3[%0d]: notify got %b want 1", k, h2s_notify); end
      n_cmp++; if (h2s_wr !== e.wr) begin n_bad++; $display("FAIL wr_rd_wr[%0d]: got %b want %b", k, h2s_wr, e.wr); end
      n_cmp++; if (h2s_data !== e.data) begin n_bad++; $display("FAIL wr_rd_data[%0d]: got %h want %h", k, h2s_data, e.data); end
      n_cmp++; if (h2s_tag !== e.tag) begin n_bad++; $display("FAIL wr_rd_tag[%0d]: got %b want %b", k, h2s_tag, e.tag); end
      $display("write_read: resp wr=%b data=%h tag=%b", h2s_wr, h2s_data, h2s_tag);
    end
    n_cmp++; if (req_cnt !== exp_req_cnt()) begin n_bad++; $display("FAIL wr_rd_req_cnt: got %0d want %0d", req_cnt, exp_req_cnt()); end
    tick();
  endtask

  task automatic test_raw();
    resp_t e;
    int got = 0;
    h2s_ack = 1'b1;
    send('{we: 1'b1, addr: 4'd7, data: 32'd5, tag: 1'b0}, 1'b1);
    tick();
    send('{we: 1'b0, addr: 4'd7, data: 32'd0, tag: 1'b1}, 1'b1);
    tick();
    s2h_notify = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (h2s_notify) begin
        got++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL raw_extra: unexpected response data=%h", h2s_data);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (h2s_wr !== e.wr || h2s_data !== e.data || h2s_tag !== e.tag) begin
            n_bad++; $display("FAIL raw_resp: got wr=%b data=%h tag=%b want wr=%b data=%h tag=%b",
                              h2s_wr, h2s_data, h2s_tag, e.wr, e.data, e.tag);
          end
          $display("raw: resp wr=%b data=%h tag=%b", h2s_wr, h2s_data, h2s_tag);
        end
      end
      tick();
    end
    n_cmp++; if (got != 2) begin n_bad++; $display("FAIL raw_count: got %0d want 2", got); end
  endtask

  task automatic test_full_ovf();
    req_entry_t reqs [6];
    reqs[0] = '{we: 1'b1, addr: 4'd1, data: 32'd11, tag: 1'b1};
    reqs[1] = '{we: 1'b0, addr: 4'd1, data: 32'd0,  tag: 1'b0};
    reqs[2] = '{we: 1'b1, addr: 4'd2, data: 32'd22, tag: 1'b1};
    reqs[3] = '{we: 1'b0, addr: 4'd3, data: 32'd0,  tag: 1'b0};
    reqs[4] = '{we: 1'b0, addr: 4'd2, data: 32'd0,  tag: 1'b1};
    reqs[5] = '{we: 1'b1, addr: 4'd1, data: 32'd99, tag: 1'b0};
    h2s_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(reqs[i], i < 5);
      if (i == 4) begin
        n_cmp++; if (s2h_busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_early: got %b want 0", s2h_busy); end
      end
      if (i == 5) begin
        n_cmp++; if (s2h_busy !== 1'b1) begin n_bad++; $display("FAIL full_busy: got %b want 1", s2h_busy); end
      end
      $display("full: request %0d sent busy=%b", i, s2h_busy);
      tick();
    end
    s2h_notify = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL full_ovf: got %b want 1", ovf); end
    n_cmp++; if (h2s_notify !== 1'b1) begin n_bad++; $display("FAIL full_notify: got %b want 1", h2s_notify); end
    n_cmp++; if (s2h_busy !== 1'b1) begin n_bad++; $display("FAIL full_busy_hold: got %b want 1", s2h_busy); end
    n_cmp++; if (req_cnt !== exp_req_cnt()) begin n_bad++; $display("FAIL full_req_cnt: got %0d want %0d", req_cnt, exp_req_cnt()); end
  endtask

  task automatic test_hold_stable();
    logic [31:0] d0;
    logic [0:0]  t0;
    logic        w0;
    h2s_ack = 1'b0;
    d0 = h2s_data; t0 = h2s_tag; w0 = h2s_wr;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++; if (h2s_notify !== 1'b1 || h2s_data !== d0 || h2s_tag !== t0 || h2s_wr !== w0) begin
        n_bad++; $display("FAIL hold_stable[%0d]: got n=%b wr=%b d=%h t=%b want n=1 wr=%b d=%h t=%b",
                          k, h2s_notify, h2s_wr, h2s_data, h2s_tag, w0, d0, t0);
      end
    end
    $display("hold: 10 cycles without ack checked");
  endtask

  task automatic test_drain_in_order();
    resp_t e;
    int got = 0;
    h2s_ack = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (h2s_notify) begin
        got++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL drain_extra: unexpected response data=%h tag=%b", h2s_data, h2s_tag);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (h2s_wr !== e.wr || h2s_data !== e.data || h2s_tag !== e.tag) begin
            n_bad++; $display("FAIL drain_resp[%0d]: got wr=%b data=%h tag=%b want wr=%b data=%h tag=%b",
                              got, h2s_wr, h2s_data, h2s_tag, e.wr, e.data, e.tag);
          end
          $display("drain: resp %0d wr=%b data=%h tag=%b", got, h2s_wr, h2s_data, h2s_tag);
        end
      end
      tick();
    end
    n_cmp++; if (got != 5) begin n_bad++; $display("FAIL drain_count: got %0d want 5", got); end
    // The dropped write of 99 must not have reached address 1.
    send('{we: 1'b0, addr: 4'd1, data: 32'd0, tag: 1'b1}, 1'b1);
    tick();
    s2h_notify = 1'b0;
    tick();
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (h2s_notify !== 1'b1 || h2s_data !== e.data) begin
      n_bad++; $display("FAIL dropped_write: got n=%b data=%h want n=1 data=%h", h2s_notify, h2s_data, e.data);
    end
    tick();
  endtask

  task automatic test_reset_mid_resp();
    int seen = 0;
    h2s_ack = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    send('{we: 1'b0, addr: 4'd3, data: 32'd0, tag: 1'b1}, 1'b1); tick();
    send('{we: 1'b0, addr: 4'd7, data: 32'd0, tag: 1'b0}, 1'b1); tick();
    send('{we: 1'b0, addr: 4'd1, data: 32'd0, tag: 1'b1}, 1'b1); tick();
    s2h_notify = 1'b0;
    for (int k = 0; k < 10 && !h2s_notify; k++) tick();
    n_cmp++; if (h2s_notify !== 1'b1) begin n_bad++; $display("FAIL midrst_reach_resp: notify got %b want 1", h2s_notify); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    n_cmp++; if (h2s_notify !== 1'b0) begin n_bad++; $display("FAIL midrst_notify: got %b want 0", h2s_notify); end
    n_cmp++; if (s2h_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", s2h_busy); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
    n_cmp++; if (req_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_req_cnt: got %0d want 0", req_cnt); end
    h2s_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (h2s_notify) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_no_resp: got %0d responses want 0", seen); end
    $display("reset_mid_resp: queued entries discarded");
  endtask

  task automatic test_random();
    resp_t       e;
    req_entry_t  r;
    int          sent = 0;
    int          got = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] pd;
    logic [0:0]  pt;
    logic        pw;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (prev_hold) begin
        n_cmp++; if (h2s_notify !== 1'b1 || h2s_data !== pd || h2s_tag !== pt || h2s_wr !== pw) begin
          n_bad++; $display("FAIL rand_hold[%0d]: got n=%b wr=%b d=%h t=%b want n=1 wr=%b d=%h t=%b",
                            cyc, h2s_notify, h2s_wr, h2s_data, h2s_tag, pw, pd, pt);
        end
      end
      h2s_ack = ($urandom_range(0, 3) != 0);
      if (h2s_notify && h2s_ack) begin
        got++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL rand_extra: unexpected response data=%h", h2s_data);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (h2s_wr !== e.wr || h2s_data !== e.data || h2s_tag !== e.tag) begin
            n_bad++; $display("FAIL rand_resp[%0d]: got wr=%b data=%h tag=%b want wr=%b data=%h tag=%b",
                              got, h2s_wr, h2s_data, h2s_tag, e.wr, e.data, e.tag);
          end
          $display("random: resp %0d wr=%b data=%h tag=%b", got, h2s_wr, h2s_data, h2s_tag);
        end
      end
      prev_hold = h2s_notify && !h2s_ack;
      pd = h2s_data; pt = h2s_tag; pw = h2s_wr;
      if (!s2h_busy && $urandom_range(0, 1) == 1) begin
        r.addr = 4'($urandom_range(0, 15));
        r.we   = !mdl_valid[r.addr] || ($urandom_range(0, 1) == 1);
        r.data = $urandom;
        r.tag  = 1'($urandom_range(0, 1));
        send(r, 1'b1);
        sent++;
      end else begin
        s2h_notify = 1'b0;
      end
      tick();
    end
    s2h_notify = 1'b0;
    h2s_ack = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      if (h2s_notify) begin
        got++;
        e = exp_q.pop_front();
        n_cmp++; if (h2s_wr !== e.wr || h2s_data !== e.data || h2s_tag !== e.tag) begin
          n_bad++; $display("FAIL rand_drain[%0d]: got wr=%b data=%h tag=%b want wr=%b data=%h tag=%b",
                            got, h2s_wr, h2s_data, h2s_tag, e.wr, e.data, e.tag);
        end
        $display("random: resp %0d wr=%b data=%h tag=%b", got, h2s_wr, h2s_data, h2s_tag);
      end
      tick();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_timeout: %0d responses outstanding want 0", exp_q.size()); end
    n_cmp++; if (got != sent || sent == 0) begin n_bad++; $display("FAIL rand_count: got %0d responses want %0d (nonzero)", got, sent); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rand_ovf: got %b want 0", ovf); end
    n_cmp++; if (req_cnt !== exp_req_cnt()) begin n_bad++; $display("FAIL rand_req_cnt: got %0d want %0d", req_cnt, exp_req_cnt()); end
  endtask

  initial begin
    rst        = 1'b1;
    s2h_notify = 1'b0;
    s2h_we     = 1'b0;
    s2h_addr   = '0;
    s2h_data   = '0;
    s2h_tag    = '0;
    h2s_ack    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mdl_mem[i]   = '0;
      mdl_valid[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_raw();
    test_full_ovf();
    test_hold_stable();
    test_drain_in_order();
    test_reset_mid_resp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
